// File: rtl/neuron_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_sequencer
//   Control stage in front of the sigmoid ALU. Each accepted start evaluates
//   one neuron. It fetches NUM_INPUTS/4 packed words from the input and weight
//   buffers and feeds them to the ALU four pairs at a time. It also drives the
//   ALU clear/accumulate strobes and captures the 5-bit sigmoid result.
//
// Ports
//   clk, n_rst            clock, synchronous active-low reset
//   start, bias_in        request a neuron evaluation, bias captured with it
//   rd_en, rd_addr        buffer read strobe / word address (data next cycle)
//   in_data, wt_data      4 unsigned inputs / 4 signed weights per word
//   input1..4, weight1..4 operand pairs to the ALU (zero when no data valid)
//   bias                  latched bias to the ALU
//   clear, accumulate     ALU accumulator control strobes
//   alu_out               sigmoid output from the ALU
//   result, result_valid  captured neuron output and its one-cycle pulse
//   busy                  high whenever not idle
// ---------------------------------------------------------------------------
module neuron_sequencer #(
    parameter int NUM_INPUTS = 64,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [3:0]        bias_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       in_data,
    input  logic [15:0]       wt_data,
    output logic [3:0]        weight1,
    output logic [3:0]        weight2,
    output logic [3:0]        weight3,
    output logic [3:0]        weight4,
    output logic [3:0]        input1,
    output logic [3:0]        input2,
    output logic [3:0]        input3,
    output logic [3:0]        input4,
    output logic [3:0]        bias,
    output logic              accumulate,
    output logic              clear,
    input  logic [4:0]        alu_out,
    output logic [4:0]        result,
    output logic              result_valid,
    output logic              busy
);

    localparam int G = NUM_INPUTS / 4;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(G - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] grp_q, grp_d;
    logic              fetch_v_q, fetch_v_d;
    logic              acc_v_q, acc_v_d;
    logic [3:0]        bias_q, bias_d;
    logic [4:0]        result_q, result_d;
    logic              rv_q, rv_d;

    // Read strobes are issued only while walking the address range.
    assign rd_en   = (state_q == S_CLEAR) || (state_q == S_STREAM);
    assign rd_addr = grp_q;
    assign clear   = (state_q == S_CLEAR);
    assign busy    = (state_q != S_IDLE);

    // Buffer data arrives one cycle after rd_en, and the ALU adder adds one
    // more register stage, so accumulate trails rd_en by exactly two cycles.
    assign fetch_v_d  = rd_en;
    assign acc_v_d    = fetch_v_q;
    assign accumulate = acc_v_q;

    assign input1  = fetch_v_q ? in_data[3:0]   : 4'd0;
    assign input2  = fetch_v_q ? in_data[7:4]   : 4'd0;
    assign input3  = fetch_v_q ? in_data[11:8]  : 4'd0;
    assign input4  = fetch_v_q ? in_data[15:12] : 4'd0;
    assign weight1 = fetch_v_q ? wt_data[3:0]   : 4'd0;
    assign weight2 = fetch_v_q ? wt_data[7:4]   : 4'd0;
    assign weight3 = fetch_v_q ? wt_data[11:8]  : 4'd0;
    assign weight4 = fetch_v_q ? wt_data[15:12] : 4'd0;

    assign bias         = bias_q;
    assign result       = result_q;
    assign result_valid = rv_q;

    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        bias_d   = bias_q;
        result_d = result_q;
        rv_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bias_d  = bias_in;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Address 0 goes out here; STREAM continues from address 1.
                if (G > 1) begin
                    grp_d   = ADDR_W'(1);
                    state_d = S_STREAM;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_STREAM: begin
                if (grp_q == LAST_ADDR) begin
                    grp_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    grp_d = grp_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                // Leave once both pipeline stages will be empty next cycle,
                // so the last accumulate has landed before CAPTURE samples.
                if (!fetch_v_d && !acc_v_d) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                result_d = alu_out;
                rv_d     = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grp_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            grp_q     <= '0;
            fetch_v_q <= 1'b0;
            acc_v_q   <= 1'b0;
            bias_q    <= 4'd0;
            result_q  <= 5'd0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            grp_q     <= grp_d;
            fetch_v_q <= fetch_v_d;
            acc_v_q   <= acc_v_d;
            bias_q    <= bias_d;
            result_q  <= result_d;
            rv_q      <= rv_d;
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
module tb_neuron_sequencer;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 64-input instance (G = 16) ----------------
    logic        start64 = 1'b0;
    logic [3:0]  bias_in64 = 4'd0;
    logic        rd_en64;
    logic [3:0]  rd_addr64;
    logic [15:0] in64 = 16'd0, wt64 = 16'd0;
    logic [3:0]  w1_64, w2_64, w3_64, w4_64, i1_64, i2_64, i3_64, i4_64, bias64;
    logic        acc64, clr64, rv64, busy64;
    logic [4:0]  alu64 = 5'd0, res64;

    neuron_sequencer #(.NUM_INPUTS(64), .ADDR_W(4)) u64 (
        .clk(clk), .n_rst(n_rst), .start(start64), .bias_in(bias_in64),
        .rd_en(rd_en64), .rd_addr(rd_addr64), .in_data(in64), .wt_data(wt64),
        .weight1(w1_64), .weight2(w2_64), .weight3(w3_64), .weight4(w4_64),
        .input1(i1_64), .input2(i2_64), .input3(i3_64), .input4(i4_64),
        .bias(bias64), .accumulate(acc64), .clear(clr64), .alu_out(alu64),
        .result(res64), .result_valid(rv64), .busy(busy64)
    );

    // ---------------- 4-input instance (G = 1) ----------------
    logic        start4 = 1'b0;
    logic [3:0]  bias_in4 = 4'd0;
    logic        rd_en4;
    logic [1:0]  rd_addr4;
    logic [15:0] in4 = 16'd0, wt4 = 16'd0;
    logic [3:0]  w1_4, w2_4, w3_4, w4_4, i1_4, i2_4, i3_4, i4_4, bias4;
    logic        acc4, clr4, rv4, busy4;
    logic [4:0]  alu4 = 5'd0, res4;

    neuron_sequencer #(.NUM_INPUTS(4), .ADDR_W(2)) u4 (
        .clk(clk), .n_rst(n_rst), .start(start4), .bias_in(bias_in4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .in_data(in4), .wt_data(wt4),
        .weight1(w1_4), .weight2(w2_4), .weight3(w3_4), .weight4(w4_4),
        .input1(i1_4), .input2(i2_4), .input3(i3_4), .input4(i4_4),
        .bias(bias4), .accumulate(acc4), .clear(clr4), .alu_out(alu4),
        .result(res4), .result_valid(rv4), .busy(busy4)
    );

    // Buffer models: registered read, data valid the cycle after rd_en.
    logic [15:0] mem_in [16];
    logic [15:0] mem_wt [16];

    always @(posedge clk) begin
        if (rd_en64) begin
            in64 <= mem_in[rd_addr64];
            wt64 <= mem_wt[rd_addr64];
        end
        if (rd_en4) begin
            in4 <= 16'h8765;
            wt4 <= 16'h2C3E;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control expectation for a run started at phase 0:
    // {busy, clear, rd_en, rd_addr[3:0], accumulate, result_valid}
    function automatic logic [8:0] ctl(input int p);
        logic b, c, r, a, v;
        logic [3:0] ad;
        if (p < 0 || p > 20) return 9'd0;
        b  = (p >= 1 && p <= 19);
        c  = (p == 1);
        r  = (p >= 1 && p <= 16);
        ad = r ? 4'(p - 1) : 4'd0;
        a  = (p >= 3 && p <= 18);
        v  = (p == 20);
        return {b, c, r, ad, a, v};
    endfunction

    typedef struct {
        logic        start;
        logic [3:0]  bias_in;
        logic [17:0] exp;   // {ctl[8:0], bias[3:0], result[4:0]}
    } vec_t;

    vec_t tbl [42];

    function automatic logic [17:0] bundle64();
        return {busy64, clr64, rd_en64, rd_addr64, acc64, rv64, bias64, res64};
    endfunction

    initial begin
        logic [3:0]  be;
        logic [4:0]  re;
        logic [4:0]  g1 [7];
        int          rv_seen;

        for (int a = 0; a < 16; a++) begin
            mem_in[a] = 16'h4321 + 16'(a) * 16'h1111;
            mem_wt[a] = 16'hF1A7 ^ {4{4'(a)}};
        end

        // Two back-to-back runs; extra start at cycle 5 must be ignored.
        for (int c = 0; c < 42; c++) begin
            be = (c == 0) ? 4'h0 : (c <= 20) ? 4'h6 : 4'hC;
            re = (c < 20) ? 5'd0 : (c < 40) ? 5'd19 : 5'd39;
            tbl[c].start   = (c == 0) || (c == 5) || (c == 20);
            tbl[c].bias_in = (c == 5) ? 4'h3 : (c == 20) ? 4'hC : 4'h6;
            tbl[c].exp     = {ctl(c) | ctl(c - 20), be, re};
        end

        // ---- reset then idle ----
        tick();
        tick();
        n_rst = 1'b1;
        chk("reset64", 32'(bundle64()), 32'd0);
        chk("reset4", 32'({busy4, clr4, rd_en4, acc4, rv4, bias4, res4}), 32'd0);
        chk("reset_ops64", 32'({i4_64, i3_64, i2_64, i1_64, w4_64, w3_64, w2_64, w1_64}), 32'd0);

        // ---- table-driven main run ----
        for (int c = 0; c < 42; c++) begin
            start64   = tbl[c].start;
            bias_in64 = tbl[c].bias_in;
            alu64     = 5'(c);
            chk($sformatf("run64_c%0d", c), 32'(bundle64()), 32'(tbl[c].exp));
            if (c == 2 || c == 3 || c == 17)
                chk($sformatf("ops64_c%0d", c),
                    {i4_64, i3_64, i2_64, i1_64, w4_64, w3_64, w2_64, w1_64},
                    {mem_in[c - 2], mem_wt[c - 2]});
            if (c == 2)
                chk("ops64_nibbles",
                    {i1_64, i2_64, i3_64, i4_64, w1_64, w2_64, w3_64, w4_64},
                    32'h1234_7A1F);
            if (c == 18)
                chk("ops64_gated", {i4_64, i3_64, i2_64, i1_64, w4_64, w3_64, w2_64, w1_64}, 32'd0);
            if (clr64 && acc64)
                chk("clear_acc_overlap", 32'(1), 32'(0));
            tick();
        end
        start64 = 1'b0;

        // ---- reset mid-run ----
        for (int c = 0; c < 9; c++) begin
            start64   = (c == 0);
            bias_in64 = 4'h5;
            n_rst     = (c != 8);
            tick();
        end
        n_rst = 1'b1;
        chk("midrst_busy", 32'(busy64), 32'd0);
        chk("midrst_acc", 32'(acc64), 32'd0);
        chk("midrst_result", 32'(res64), 32'd0);
        chk("midrst_bias", 32'(bias64), 32'd0);
        rv_seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (rv64) rv_seen++;
            tick();
        end
        chk("midrst_no_valid", 32'(rv_seen), 32'd0);

        // ---- G = 1 instance ----
        // {busy, clear, rd_en, accumulate, result_valid}
        g1 = '{5'b00000, 5'b11100, 5'b10000, 5'b10010, 5'b10000, 5'b00001, 5'b00000};
        for (int c = 0; c < 7; c++) begin
            start4   = (c == 0);
            bias_in4 = (c == 0) ? 4'h9 : 4'h2;
            alu4     = 5'(c + 7);
            chk($sformatf("g1_ctl_c%0d", c), 32'({busy4, clr4, rd_en4, acc4, rv4}), 32'(g1[c]));
            if (c == 1) chk("g1_addr", 32'(rd_addr4), 32'd0);
            if (c == 2)
                chk("g1_ops", {i4_4, i3_4, i2_4, i1_4, w4_4, w3_4, w2_4, w1_4}, 32'h8765_2C3E);
            if (c == 5) begin
                chk("g1_result", 32'(res4), 32'd11);
                chk("g1_bias", 32'(bias4), 32'h9);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
